ecc_rd_sched: RTL and testbench

Round-robin read scheduler that shares one single-port ECC-protected SRAM and one registered hamming decoder among NUM_PORTS requesters. It issues SRAM reads and feeds the raw data and code to the decoder. It routes corrected data back to the granted port with a fixed 3-cycle latency. On a detected error it drains the pipeline and schedules a one-shot scrub write of the corrected word back to the SRAM.

---
 rtl/ecc_rd_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/ecc_rd_sched.sv | 127 ++++++++++++
 tb/tb_ecc_rd_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_rd_sched_pkg.sv
// rtl/ecc_rd_sched_pkg.sv - shared types and constants for the ECC read scheduler
package ecc_rd_sched_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_SCRUB = 2'd2
  } state_t;

  localparam int PIPE_LAT = 3;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, searches from ptr+1 modulo NUM_PORTS
module rr_arbiter
  import ecc_rd_sched_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [idx_w(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [idx_w(NUM_PORTS)-1:0] idx
);

  localparam int IW = idx_w(NUM_PORTS);

  int          p;
  logic [IW-1:0] pi;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = 0;
    pi    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      p  = (int'(ptr) + i) % NUM_PORTS;
      pi = IW'(p);
      if (!found && req[pi]) begin
        found     = 1'b1;
        grant[pi] = 1'b1;
        idx       = pi;
      end
    end
  end

endmodule

// File: rtl/ecc_rd_sched.sv
// rtl/ecc_rd_sched.sv - round-robin read scheduler sharing one ECC SRAM and decoder,
// with fixed 3-cycle response latency and one-shot scrub write on detected errors
module ecc_rd_sched
  import ecc_rd_sched_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int CODE_W    = 6,
  parameter int ERR_CNT_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_PORTS-1:0]        i_req_vld,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
  output logic [NUM_PORTS-1:0]        o_req_rdy,
  output logic                        o_mem_rd_en,
  output logic [ADDR_W-1:0]           o_mem_rd_addr,
  input  logic [DATA_W-1:0]           i_mem_rd_data,
  input  logic [CODE_W-1:0]           i_mem_rd_code,
  output logic [DATA_W-1:0]           o_dec_data,
  output logic [CODE_W-1:0]           o_dec_code,
  output logic                        o_dec_vld,
  input  logic [DATA_W-1:0]           i_dec_data,
  input  logic                        i_dec_err,
  output logic [NUM_PORTS-1:0]        o_rsp_vld,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic                        o_scrub_wr_en,
  output logic [ADDR_W-1:0]           o_scrub_wr_addr,
  output logic [DATA_W-1:0]           o_scrub_wr_data,
  input  logic                        i_scrub_wr_rdy,
  output logic [ERR_CNT_W-1:0]        o_err_cnt,
  output logic                        o_scrub_drop,
  output logic                        o_busy
);

  localparam int IW      = idx_w(NUM_PORTS);
  localparam int CPL_STG = PIPE_LAT - 2;
  localparam int RSP_STG = PIPE_LAT - 1;

  typedef struct packed {
    logic              vld;
    logic [IW-1:0]     idx;
    logic [ADDR_W-1:0] addr;
  } trk_t;

  state_t            state;
  logic [IW-1:0]     ptr;
  trk_t              pipe [PIPE_LAT];
  logic [NUM_PORTS-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic [ADDR_W-1:0] addr_arr [NUM_PORTS];
  logic              accept;
  logic              cpl;
  logic              cpl_err;
  logic              pipe_empty;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_addr
    assign addr_arr[k] = i_req_addr[k*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req   (i_req_vld),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign o_req_rdy     = (state == S_RUN) ? gnt : '0;
  assign accept        = |o_req_rdy;
  assign o_mem_rd_en   = accept;
  assign o_mem_rd_addr = accept ? addr_arr[gnt_idx] : '0;

  assign o_dec_data = i_mem_rd_data;
  assign o_dec_code = i_mem_rd_code;
  assign o_dec_vld  = pipe[0].vld;

  // Decoder output belongs to the read tracked in the middle stage.
  assign cpl        = pipe[CPL_STG].vld;
  assign cpl_err    = cpl && i_dec_err;
  assign pipe_empty = !(pipe[0].vld || pipe[1].vld || pipe[2].vld);

  assign o_rsp_vld     = pipe[RSP_STG].vld ? (NUM_PORTS'(1) << pipe[RSP_STG].idx) : '0;
  assign o_scrub_wr_en = (state == S_SCRUB);
  assign o_busy        = !pipe_empty || (state != S_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_RUN;
      ptr             <= IW'(NUM_PORTS - 1);
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
      o_rsp_data      <= '0;
      o_scrub_wr_addr <= '0;
      o_scrub_wr_data <= '0;
      o_err_cnt       <= '0;
      o_scrub_drop    <= 1'b0;
    end else begin
      pipe[0].vld  <= accept;
      pipe[0].idx  <= gnt_idx;
      pipe[0].addr <= o_mem_rd_addr;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];

      if (accept) ptr <= gnt_idx;
      if (cpl) o_rsp_data <= i_dec_data;

      o_scrub_drop <= 1'b0;
      if (cpl_err) begin
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
        // The scrub slot is free exactly while running; later errors are only counted.
        if (state == S_RUN) begin
          o_scrub_wr_addr <= pipe[CPL_STG].addr;
          o_scrub_wr_data <= i_dec_data;
        end else begin
          o_scrub_drop <= 1'b1;
        end
      end

      case (state)
        S_RUN:   if (cpl_err) state <= S_DRAIN;
        S_DRAIN: if (pipe_empty) state <= S_SCRUB;
        S_SCRUB: if (i_scrub_wr_rdy) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_rd_sched.sv
// tb/tb_ecc_rd_sched.sv - bench for ecc_rd_sched with SRAM/decoder models and reference model
module tb_ecc_rd_sched;

  localparam int NP = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam int EW = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [NP-1:0]     i_req_vld = '0;
  logic [NP*AW-1:0]  i_req_addr = '0;
  logic [NP-1:0]     o_req_rdy;
  logic              o_mem_rd_en;
  logic [AW-1:0]     o_mem_rd_addr;
  logic [DW-1:0]     i_mem_rd_data = '0;
  logic [CW-1:0]     i_mem_rd_code = '0;
  logic [DW-1:0]     o_dec_data;
  logic [CW-1:0]     o_dec_code;
  logic              o_dec_vld;
  logic [DW-1:0]     i_dec_data = '0;
  logic              i_dec_err = 1'b0;
  logic [NP-1:0]     o_rsp_vld;
  logic [DW-1:0]     o_rsp_data;
  logic              o_scrub_wr_en;
  logic [AW-1:0]     o_scrub_wr_addr;
  logic [DW-1:0]     o_scrub_wr_data;
  logic              i_scrub_wr_rdy = 1'b0;
  logic [EW-1:0]     o_err_cnt;
  logic              o_scrub_drop;
  logic              o_busy;

  ecc_rd_sched #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .CODE_W(CW), .ERR_CNT_W(EW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_vld(i_req_vld), .i_req_addr(i_req_addr),
    .o_req_rdy(o_req_rdy), .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr),
    .i_mem_rd_data(i_mem_rd_data), .i_mem_rd_code(i_mem_rd_code), .o_dec_data(o_dec_data),
    .o_dec_code(o_dec_code), .o_dec_vld(o_dec_vld), .i_dec_data(i_dec_data),
    .i_dec_err(i_dec_err), .o_rsp_vld(o_rsp_vld), .o_rsp_data(o_rsp_data),
    .o_scrub_wr_en(o_scrub_wr_en), .o_scrub_wr_addr(o_scrub_wr_addr),
    .o_scrub_wr_data(o_scrub_wr_data), .i_scrub_wr_rdy(i_scrub_wr_rdy),
    .o_err_cnt(o_err_cnt), .o_scrub_drop(o_scrub_drop), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    bit          err;
    logic [9:0]  addr;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [1024];
  bit          err_flag [1024];

  exp_t        q [$];
  int          m_cyc = 0;
  int          m_mode = 0;
  int          m_ptr = NP - 1;
  int          m_cnt = 0;
  int          m_last = -100;
  bit          m_prev_acc = 0;
  logic [31:0] m_rsp_data = '0;
  logic [9:0]  m_saddr = '0;
  logic [31:0] m_sdata = '0;

  logic        cap_rd_en = 0;
  logic [9:0]  cap_rd_addr = '0;
  logic        cap_dec_vld = 0;
  logic [31:0] cap_dec_data = '0;
  logic [5:0]  cap_dec_code = '0;

  logic [NP-1:0] last_rdy;
  logic [NP-1:0] last_rsp;
  logic          last_scrub;
  logic [9:0]    last_saddr;
  logic [31:0]   last_sdata;
  logic          last_drop;
  logic [EW-1:0] last_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic set_addr(input int p, input logic [9:0] a);
    i_req_addr[p*AW +: AW] = a;
  endtask

  task automatic cycle();
    exp_t          e;
    logic [NP-1:0] e_rdy;
    logic [NP-1:0] e_rsp;
    logic [9:0]    e_addr;
    bit            e_drop, e_busy, had, e_scrub, e_dvld;
    int            p;
    @(negedge i_clk);
    e_rsp = '0; e_drop = 0; had = 0;
    while (q.size() > 0 && q[0].due == m_cyc) begin
      e = q.pop_front();
      had = 1;
      e_rsp = NP'(1) << e.port;
      m_rsp_data = e.data;
      if (e.err) begin
        if (m_cnt != (1 << EW) - 1) m_cnt++;
        if (m_mode == 0) begin
          m_saddr = e.addr; m_sdata = e.data; m_mode = 1;
        end else e_drop = 1;
      end
    end
    if (m_mode == 1 && m_cyc >= m_last + 5) m_mode = 2;
    e_busy = had || (q.size() > 0) || (m_mode != 0);
    e_rdy = '0; e_addr = '0;
    if (m_mode == 0) begin
      for (int i = 1; i <= NP; i++) begin
        p = (m_ptr + i) % NP;
        if (e_rdy == '0 && i_req_vld[p]) begin
          e_rdy  = NP'(1) << p;
          e_addr = i_req_addr[p*AW +: AW];
          q.push_back('{due: m_cyc + 3, port: p, data: mem[e_addr], err: err_flag[e_addr], addr: e_addr});
          m_ptr  = p;
          m_last = m_cyc;
        end
      end
    end
    e_dvld = m_prev_acc;
    m_prev_acc = (e_rdy != '0);
    e_scrub = (m_mode == 2);
    chk("req_rdy", 64'(o_req_rdy), 64'(e_rdy));
    chk("mem_rd_en", 64'(o_mem_rd_en), 64'(e_rdy != '0));
    chk("mem_rd_addr", 64'(o_mem_rd_addr), 64'(e_addr));
    chk("dec_vld", 64'(o_dec_vld), 64'(e_dvld));
    chk("rsp_vld", 64'(o_rsp_vld), 64'(e_rsp));
    chk("rsp_data", 64'(o_rsp_data), 64'(m_rsp_data));
    chk("err_cnt", 64'(o_err_cnt), 64'(m_cnt));
    chk("scrub_drop", 64'(o_scrub_drop), 64'(e_drop));
    chk("scrub_wr_en", 64'(o_scrub_wr_en), 64'(e_scrub));
    if (e_scrub) begin
      chk("scrub_wr_addr", 64'(o_scrub_wr_addr), 64'(m_saddr));
      chk("scrub_wr_data", 64'(o_scrub_wr_data), 64'(m_sdata));
    end
    chk("busy", 64'(o_busy), 64'(e_busy));
    last_rdy = o_req_rdy; last_rsp = o_rsp_vld; last_scrub = o_scrub_wr_en;
    last_saddr = o_scrub_wr_addr; last_sdata = o_scrub_wr_data;
    last_drop = o_scrub_drop; last_cnt = o_err_cnt;
    cap_rd_en = o_mem_rd_en; cap_rd_addr = o_mem_rd_addr;
    cap_dec_vld = o_dec_vld; cap_dec_data = o_dec_data; cap_dec_code = o_dec_code;
    if (m_mode == 2 && i_scrub_wr_rdy) m_mode = 0;
    m_cyc++;
    @(posedge i_clk);
    #1;
    // SRAM model flips bit (addr%32) on flagged words; code = {bit, err}; decoder undoes it.
    if (cap_rd_en) begin
      i_mem_rd_data = mem[cap_rd_addr] ^ (err_flag[cap_rd_addr] ? (32'd1 << cap_rd_addr[4:0]) : 32'd0);
      i_mem_rd_code = {cap_rd_addr[4:0], err_flag[cap_rd_addr]};
    end else begin
      i_mem_rd_data = '0; i_mem_rd_code = '0;
    end
    if (cap_dec_vld) begin
      i_dec_err  = cap_dec_code[0];
      i_dec_data = cap_dec_data ^ (cap_dec_code[0] ? (32'd1 << cap_dec_code[5:1]) : 32'd0);
    end else begin
      i_dec_err = 1'b0; i_dec_data = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req_vld = '0; i_mem_rd_data = '0; i_mem_rd_code = '0;
    i_dec_data = '0; i_dec_err = 1'b0; i_scrub_wr_rdy = 1'b0;
    #1;
    chk("rst req_rdy", 64'(o_req_rdy), 64'd0);
    chk("rst mem_rd_en", 64'(o_mem_rd_en), 64'd0);
    chk("rst mem_rd_addr", 64'(o_mem_rd_addr), 64'd0);
    chk("rst dec_data", 64'(o_dec_data), 64'd0);
    chk("rst dec_code", 64'(o_dec_code), 64'd0);
    chk("rst dec_vld", 64'(o_dec_vld), 64'd0);
    chk("rst rsp_vld", 64'(o_rsp_vld), 64'd0);
    chk("rst rsp_data", 64'(o_rsp_data), 64'd0);
    chk("rst scrub_wr_en", 64'(o_scrub_wr_en), 64'd0);
    chk("rst scrub_wr_addr", 64'(o_scrub_wr_addr), 64'd0);
    chk("rst scrub_wr_data", 64'(o_scrub_wr_data), 64'd0);
    chk("rst err_cnt", 64'(o_err_cnt), 64'd0);
    chk("rst scrub_drop", 64'(o_scrub_drop), 64'd0);
    chk("rst busy", 64'(o_busy), 64'd0);
    q.delete();
    m_mode = 0; m_ptr = NP - 1; m_cnt = 0; m_last = -100; m_prev_acc = 0;
    m_rsp_data = '0; m_saddr = '0; m_sdata = '0;
    cap_rd_en = 0; cap_dec_vld = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int drops;
    for (int a = 0; a < 1024; a++) begin
      mem[a] = $urandom;
      err_flag[a] = 0;
    end
    mem[10'h005] = 32'hDEADBEEF;
    mem[10'h03A] = 32'h12345678; err_flag[10'h03A] = 1;
    err_flag[10'h010] = 1; err_flag[10'h011] = 1; err_flag[10'h020] = 1;

    // Port 2 alone, clean word
    apply_reset();
    set_addr(2, 10'h005); i_req_vld = 4'b0100;
    cycle();
    chk("single grant", 64'(last_rdy), 64'h4);
    i_req_vld = '0;
    repeat (3) cycle();
    chk("single rsp_vld", 64'(last_rsp), 64'h4);
    chk("single rsp_data", 64'(o_rsp_data), 64'hDEADBEEF);
    chk("single err_cnt", 64'(last_cnt), 64'd0);
    cycle();

    // All ports continuously from reset: 0,1,2,3,0
    apply_reset();
    for (int p = 0; p < NP; p++) set_addr(p, 10'(10'h100 + p));
    i_req_vld = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr order", 64'(last_rdy), 64'(4'b0001 << (k % 4)));
    end
    i_req_vld = '0;
    repeat (4) cycle();

    // Single-bit error on 0x3A from port 1, scrub stalled 5 cycles
    apply_reset();
    set_addr(1, 10'h03A); i_req_vld = 4'b0010;
    cycle();
    chk("err grant", 64'(last_rdy), 64'h2);
    i_req_vld = '0;
    for (int k = 0; k < 20 && !last_scrub; k++) cycle();
    chk("err scrub seen", 64'(last_scrub), 64'd1);
    chk("err scrub addr", 64'(last_saddr), 64'h03A);
    chk("err scrub data", 64'(last_sdata), 64'h12345678);
    chk("err cnt", 64'(last_cnt), 64'd1);
    for (int p = 0; p < NP; p++) set_addr(p, 10'(10'h200 + p));
    i_req_vld = 4'hF;
    repeat (5) begin
      cycle();
      chk("scrub stall rdy", 64'(last_rdy), 64'd0);
    end
    i_scrub_wr_rdy = 1'b1;
    cycle();
    chk("scrub accept rdy", 64'(last_rdy), 64'd0);
    i_scrub_wr_rdy = 1'b0;
    cycle();
    chk("grant resume", 64'(last_rdy), 64'h4);
    i_req_vld = '0;
    repeat (4) cycle();

    // Two back-to-back erroring reads
    apply_reset();
    set_addr(0, 10'h010); set_addr(1, 10'h011); i_req_vld = 4'b0011;
    cycle();
    i_req_vld = 4'b0010;
    cycle();
    i_req_vld = '0;
    drops = 0;
    repeat (10) begin
      cycle();
      drops += int'(last_drop);
    end
    chk("b2b drops", 64'(drops), 64'd1);
    chk("b2b err_cnt", 64'(last_cnt), 64'd2);
    chk("b2b scrub addr", 64'(last_saddr), 64'h010);
    i_scrub_wr_rdy = 1'b1;
    cycle();
    i_scrub_wr_rdy = 1'b0;
    cycle();

    // Counter saturation with a 2-bit counter
    apply_reset();
    i_scrub_wr_rdy = 1'b1;
    set_addr(0, 10'h010);
    for (int k = 0; k < 5; k++) begin
      i_req_vld = 4'b0001;
      cycle();
      i_req_vld = '0;
      repeat (8) cycle();
    end
    chk("sat err_cnt", 64'(last_cnt), 64'd3);
    i_scrub_wr_rdy = 1'b0;

    // Reset while draining with two reads in flight
    apply_reset();
    set_addr(0, 10'h020); set_addr(1, 10'h021); set_addr(2, 10'h022);
    i_req_vld = 4'b0111; cycle();
    i_req_vld = 4'b0110; cycle();
    i_req_vld = 4'b0100; cycle();
    i_req_vld = '0;      cycle();
    apply_reset();
    repeat (8) begin
      cycle();
      chk("post-rst rsp", 64'(last_rsp), 64'd0);
      chk("post-rst scrub", 64'(last_scrub), 64'd0);
    end
    i_req_vld = 4'hF;
    cycle();
    chk("post-rst first grant", 64'(last_rdy), 64'h1);
    i_req_vld = '0;
    repeat (4) cycle();

    // Randomized traffic
    for (int a = 0; a < 64; a++) err_flag[a] = ($urandom_range(0, 7) == 0);
    for (int p = 0; p < NP; p++) set_addr(p, 10'($urandom_range(0, 63)));
    i_req_vld = 4'($urandom);
    repeat (300) begin
      cycle();
      for (int p = 0; p < NP; p++) begin
        if (last_rdy[p] || !i_req_vld[p]) begin
          i_req_vld[p] = ($urandom_range(0, 2) != 0);
          set_addr(p, 10'($urandom_range(0, 63)));
        end else if ($urandom_range(0, 15) == 0) begin
          i_req_vld[p] = 1'b0;
        end
      end
      i_scrub_wr_rdy = ($urandom_range(0, 3) == 0);
    end
    i_req_vld = '0;
    i_scrub_wr_rdy = 1'b1;
    repeat (12) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
